// File: rtl/parking_pkg.sv
// parking_pkg -- shared types and constants for the parking sensor generator.
//   cmd_t        : sequence command encoding (ENTRY, EXIT, PED, RSVD)
//   psg_state_t  : generator FSM states
//   PAT_*        : {sensor_a, sensor_b} output patterns
//   Helpers pick the first/third phase pattern and qualify a command.
//   Optional feature macro: PSG_PED_EN (pedestrian sequence support).
package parking_pkg;

    typedef enum logic [1:0] {
        CMD_ENTRY = 2'b00,
        CMD_EXIT  = 2'b01,
        CMD_PED   = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } psg_state_t;

    localparam logic [1:0] PAT_CLEAR = 2'b00;
    localparam logic [1:0] PAT_A     = 2'b10;
    localparam logic [1:0] PAT_AB    = 2'b11;
    localparam logic [1:0] PAT_B     = 2'b01;

    // EXIT enters from the inner sensor; ENTRY and PED from the outer one.
    function automatic logic [1:0] first_pat(input cmd_t c);
        case (c)
            CMD_EXIT: first_pat = PAT_B;
            default:  first_pat = PAT_A;
        endcase
    endfunction

    // Last occupied phase mirrors the first one.
    function automatic logic [1:0] third_pat(input cmd_t c);
        case (c)
            CMD_EXIT: third_pat = PAT_A;
            default:  third_pat = PAT_B;
        endcase
    endfunction

    // Commands that start a sequence; PED only when the feature is built in.
    function automatic logic cmd_valid(input cmd_t c);
        case (c)
            CMD_ENTRY: cmd_valid = 1'b1;
            CMD_EXIT:  cmd_valid = 1'b1;
`ifdef PSG_PED_EN
            CMD_PED:   cmd_valid = 1'b1;
`endif
            default:   cmd_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parking_sensor_gen_phase_timer.sv
// phase_timer -- loadable down-counter used for both phase and gap timing.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : cycles remaining minus one
//   expired    : count has reached zero (last cycle of the interval)
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count_r;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == 8'd0);

endmodule

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen -- emulates a two-sensor (outer A, inner B) vehicle
// detector, producing ENTRY/EXIT (and optionally PED) blocking sequences.
//   clk, reset          : clock, synchronous active-high reset
//   start, cmd, rep     : request, sequence type, repeat count (0 means 1)
//   sensor_a, sensor_b  : registered emulated sensor outputs (1 = blocked)
//   busy, done          : sequence in progress / one-cycle completion pulse
//   entries_sent, exits_sent : wrapping counts of completed sequences
// Optional feature macro: PSG_PED_EN enables the PED (PH1 -> GAP) sequence.
module parking_sensor_gen
    import parking_pkg::*;
#(
    parameter int PHASE_CYCLES = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [3:0]       rep,
    output logic             sensor_a,
    output logic             sensor_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] entries_sent,
    output logic [CNT_W-1:0] exits_sent
);

    localparam logic [7:0]       PH_LOAD  = 8'(PHASE_CYCLES - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    psg_state_t       state_r;
    cmd_t             cmd_r;
    cmd_t             cmd_s;
    logic [3:0]       rep_left_r;
    logic [1:0]       sens_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] entries_r;
    logic [CNT_W-1:0] exits_r;
    logic             accept_s;
    logic             load_s;
    logic [7:0]       load_val_s;
    logic             expired_s;

    assign cmd_s = cmd_t'(cmd);

    phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Timer reload: on acceptance and on every phase/gap boundary; the
    // reload value is the length of the interval being entered.
    always_comb begin
        accept_s   = 1'b0;
        load_s     = 1'b0;
        load_val_s = PH_LOAD;
        case (state_r)
            ST_IDLE: begin
                if (start && cmd_valid(cmd_s)) begin
                    accept_s = 1'b1;
                    load_s   = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_PH1: begin
                if (expired_s) begin
                    load_s = 1'b1;
`ifdef PSG_PED_EN
                    load_val_s = (cmd_r == CMD_PED) ? GAP_LOAD : PH_LOAD;
`endif
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PH2: begin
                if (expired_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PH3: begin
                if (expired_s) begin
                    load_s     = 1'b1;
                    load_val_s = GAP_LOAD;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (expired_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Sequence FSM with registered sensor, status and counter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cmd_r      <= CMD_ENTRY;
            rep_left_r <= 4'd0;
            sens_r     <= PAT_CLEAR;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            entries_r  <= {CNT_W{1'b0}};
            exits_r    <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_r      <= cmd_s;
                        rep_left_r <= (rep == 4'd0) ? 4'd0 : rep - 4'd1;
                        sens_r     <= first_pat(cmd_s);
                        busy_r     <= 1'b1;
                        state_r    <= ST_PH1;
                    end
                end
                ST_PH1: begin
                    if (expired_s) begin
`ifdef PSG_PED_EN
                        if (cmd_r == CMD_PED) begin
                            sens_r  <= PAT_CLEAR;
                            state_r <= ST_GAP;
                        end else begin
                            sens_r  <= PAT_AB;
                            state_r <= ST_PH2;
                        end
`else
                        sens_r  <= PAT_AB;
                        state_r <= ST_PH2;
`endif
                    end
                end
                ST_PH2: begin
                    if (expired_s) begin
                        sens_r  <= third_pat(cmd_r);
                        state_r <= ST_PH3;
                    end
                end
                ST_PH3: begin
                    if (expired_s) begin
                        sens_r  <= PAT_CLEAR;
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (expired_s) begin
                        if (cmd_r == CMD_ENTRY) begin
                            entries_r <= entries_r + CNT_ONE;
                        end
                        if (cmd_r == CMD_EXIT) begin
                            exits_r <= exits_r + CNT_ONE;
                        end
                        // Next repeat starts straight from the gap's last cycle.
                        if (rep_left_r != 4'd0) begin
                            rep_left_r <= rep_left_r - 4'd1;
                            sens_r     <= first_pat(cmd_r);
                            state_r    <= ST_PH1;
                        end else begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    sens_r  <= PAT_CLEAR;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sensor_a     = sens_r[1];
    assign sensor_b     = sens_r[0];
    assign busy         = busy_r;
    assign done         = done_r;
    assign entries_sent = entries_r;
    assign exits_sent   = exits_r;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench for parking_sensor_gen (PHASE_CYCLES=2, GAP_CYCLES=4).
// A second instance with CNT_W=2 shares all inputs to observe counter wrap.
module tb_parking_sensor_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cmd;
    logic [3:0] rep;

    logic       sensor_a, sensor_b, busy, done;
    logic [7:0] entries_sent, exits_sent;
    logic       w_sensor_a, w_sensor_b, w_busy, w_done;
    logic [1:0] w_entries_sent, w_exits_sent;

    int errors = 0;
    int checks = 0;

    logic [1:0] ent_pat [10] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01,
                                 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] ext_pat [10] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10,
                                 2'b00, 2'b00, 2'b00, 2'b00};

    parking_sensor_gen #(.PHASE_CYCLES(2), .GAP_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rep(rep),
        .sensor_a(sensor_a), .sensor_b(sensor_b), .busy(busy), .done(done),
        .entries_sent(entries_sent), .exits_sent(exits_sent)
    );

    parking_sensor_gen #(.PHASE_CYCLES(2), .GAP_CYCLES(4), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rep(rep),
        .sensor_a(w_sensor_a), .sensor_b(w_sensor_b), .busy(w_busy), .done(w_done),
        .entries_sent(w_entries_sent), .exits_sent(w_exits_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk nrep full sequences from the first PH1 cycle; optionally spray
    // random start/cmd/rep every cycle, which must all be ignored.
    task automatic run_pat(input string tag, input bit is_exit, input int nrep, input bit noise);
        for (int r = 0; r < nrep; r++) begin
            for (int i = 0; i < 10; i++) begin
                chk({tag, "_pat"}, {30'd0, sensor_a, sensor_b}, {30'd0, is_exit ? ext_pat[i] : ent_pat[i]});
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
                if (noise) begin
                    start = 1'b1;
                    cmd   = 2'($urandom_range(0, 3));
                    rep   = 4'($urandom_range(0, 15));
                end
                tick();
            end
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [3:0] n);
        start = 1'b1;
        cmd   = c;
        rep   = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int dones;
        reset = 1'b1; start = 1'b0; cmd = 2'b00; rep = 4'd0;
        tick(); tick();
        chk("rst_sens", {30'd0, sensor_a, sensor_b}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ent", {24'd0, entries_sent}, 32'd0);
        chk("rst_ext", {24'd0, exits_sent}, 32'd0);
        reset = 1'b0;
        tick();

        // ENTRY x1; a start during the done cycle must be dropped.
        issue(2'b00, 4'd1);
        run_pat("entry1", 1'b0, 1, 1'b0);
        chk("entry1_done", {31'd0, done}, 32'd1);
        chk("entry1_busy0", {31'd0, busy}, 32'd0);
        chk("entry1_cnt", {24'd0, entries_sent}, 32'd1);
        start = 1'b1; cmd = 2'b00; rep = 4'd1;
        tick();
        start = 1'b0;
        chk("done_start_ign", {31'd0, busy}, 32'd0);
        chk("done_pulse_once", {31'd0, done}, 32'd0);

        // EXIT x3 back to back, random start/cmd spam while busy.
        issue(2'b01, 4'd3);
        run_pat("exit3", 1'b1, 3, 1'b1);
        start = 1'b0;
        chk("exit3_done", {31'd0, done}, 32'd1);
        chk("exit3_cnt", {24'd0, exits_sent}, 32'd3);
        chk("exit3_ent", {24'd0, entries_sent}, 32'd1);
        tick();
        chk("exit3_idle", {31'd0, busy}, 32'd0);

        // rep=0 runs once; spam must not add sequences.
        issue(2'b00, 4'd0);
        run_pat("entry0", 1'b0, 1, 1'b1);
        start = 1'b0;
        chk("entry0_done", {31'd0, done}, 32'd1);
        chk("entry0_cnt", {24'd0, entries_sent}, 32'd2);
        chk("entry0_ext", {24'd0, exits_sent}, 32'd3);
        tick();

        // Reset during PH2 aborts with no done pulse.
        issue(2'b00, 4'd1);
        tick(); tick();
        chk("abort_ph2", {30'd0, sensor_a, sensor_b}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_sens", {30'd0, sensor_a, sensor_b}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ent", {24'd0, entries_sent}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        chk("abort_nodone", dones, 32'd0);

        // RSVD is always ignored.
        issue(2'b11, 4'd1);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rsvd_idle", {31'd0, busy}, 32'd0);

`ifdef PSG_PED_EN
        issue(2'b10, 4'd1);
        for (int i = 0; i < 6; i++) begin
            chk("ped_pat", {30'd0, sensor_a, sensor_b}, (i < 2) ? 32'd2 : 32'd0);
            chk("ped_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("ped_done", {31'd0, done}, 32'd1);
        chk("ped_ent", {24'd0, entries_sent}, 32'd0);
        chk("ped_ext", {24'd0, exits_sent}, 32'd0);
        tick();
`else
        issue(2'b10, 4'd1);
        chk("ped_off_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("ped_off_idle", {31'd0, busy}, 32'd0);
        chk("ped_off_sens", {30'd0, sensor_a, sensor_b}, 32'd0);
`endif

        // Five ENTRY sequences: 8-bit counter reads 5, 2-bit counter wraps to 1.
        issue(2'b00, 4'd5);
        run_pat("entry5", 1'b0, 5, 1'b0);
        chk("entry5_done", {31'd0, done}, 32'd1);
        chk("entry5_cnt", {24'd0, entries_sent}, 32'd5);
        chk("wrap_cnt", {30'd0, w_entries_sent}, 32'd1);
        chk("wrap_ext", {30'd0, w_exits_sent}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_sensor_gen.md
PARKING_SENSOR_GEN -- requirements
Module: parking_sensor_gen

Interface
REQ-001 Parameter PHASE_CYCLES, default 2: cycles each sensor phase is held, legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 4: cycles both sensors stay clear after each sequence, legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of the sent-event counters.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse; sampled only while busy=0.
REQ-007 cmd  input  2  sequence type (cmd_t): ENTRY=00, EXIT=01, PED=10, RSVD=11.
REQ-008 rep  input  4  sequence count; 0 is treated as 1.
REQ-009 sensor_a  output  1  emulated outer sensor, 1 = blocked.
REQ-010 sensor_b  output  1  emulated inner sensor, 1 = blocked.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when the final sequence's gap ends.
REQ-013 entries_sent, exits_sent  output  CNT_W each  count of completed ENTRY and EXIT sequences.

Function
REQ-014 Output pattern {sensor_a,sensor_b} for ENTRY SHALL be 10, 11, 01, then 00 gap.
REQ-015 Output pattern for EXIT SHALL be 01, 11, 10, then 00 gap.
REQ-016 Output pattern for PED SHALL be 10, then 00 gap.
REQ-017 Each occupied phase SHALL last exactly PHASE_CYCLES cycles; each gap SHALL last exactly GAP_CYCLES cycles.
REQ-018 FSM states: IDLE, PH1, PH2, PH3, GAP, DONE.
REQ-019 PED SHALL go PH1 -> GAP and skip PH2/PH3.
REQ-020 start=1 in IDLE with a valid cmd at cycle t: cmd and rep are latched; busy=1 and the first phase is on the outputs at t+1.
REQ-021 start while busy=1 SHALL be ignored; cmd and rep changes after acceptance SHALL have no effect.
REQ-022 start with cmd=RSVD SHALL be ignored: busy stays 0, no counter changes.
REQ-023 At the end of a GAP with repeats remaining, PH1 of the next sequence SHALL follow immediately with no extra cycle.
REQ-024 At the end of the final GAP, state is DONE for one cycle: done=1, busy=0, then IDLE.
REQ-025 A start coinciding with done=1 SHALL be ignored; it is accepted from the following cycle.
REQ-026 A counter SHALL increment on the last GAP cycle of each ENTRY/EXIT sequence, once per repeat.
REQ-027 Counters SHALL wrap modulo 2^CNT_W.
REQ-028 PED sequences SHALL NOT change either counter.
REQ-029 Sensor outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-030 While reset=1, the following SHALL hold at the next edge: state=IDLE, sensor_a=0, sensor_b=0, busy=0, done=0, both counters=0, phase timer and repeat counter cleared.
REQ-031 Reset asserted mid-sequence SHALL abort it without a done pulse and without a counter update.

Configuration
REQ-032 Macro PSG_PED_EN: when defined, PED behaves per REQ-016/REQ-019.
REQ-033 When PSG_PED_EN is not defined, cmd=PED SHALL be treated as RSVD (ignored), and no PED-only logic is synthesised.

Structure
REQ-034 Package parking_pkg SHALL hold cmd_t, the psg_state_t enum and the sensor pattern constants (PAT_CLEAR=00, PAT_A=10, PAT_AB=11, PAT_B=01).
REQ-035 Sub-module phase_timer SHALL be a loadable down-counter with an expired flag, reused for phase and gap timing.

Verification (PHASE_CYCLES=2, GAP_CYCLES=4)
REQ-036 ENTRY, rep=1, start at cycle 10:
  - outputs 10 @11-12, 11 @13-14, 01 @15-16, 00 @17-20;
  - done=1 @21, entries_sent=1.
REQ-037 EXIT, rep=3:
  - 30 busy cycles of back-to-back sequences with no idle gap between repeats;
  - exits_sent=3, one done pulse.
REQ-038 start pulsed every cycle while busy, with changing cmd:
  - outputs match the first command only;
  - exactly one sequence is counted.
REQ-039 Reset asserted at PH2 of an ENTRY:
  - next cycle outputs 00, busy=0, no done pulse;
  - entries_sent=0.
REQ-040 PED with PSG_PED_EN defined:
  - 10 for 2 cycles, then 00 for 4 cycles, then done;
  - counters unchanged.
  Without the macro, PED or RSVD leaves busy=0.
REQ-041 CNT_W=2, 5 ENTRY sequences: entries_sent ends at 1 (wrap-around).
